// File: rtl/cpu_datapath_if.sv
// Control/status bundle between the processor control unit (master) and
// cpu_datapath (slave), including the bench/boot program-load port.
interface cpu_datapath_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
);
  logic              ir_load;
  logic              pc_load;
  logic              jmp_mux;
  logic              mem_inst;
  logic              mem_wr;
  logic [1:0]        a_sel;
  logic              a_load;
  logic              sub;
  logic              halt;
  logic [DATA_W-1:0] in_data;
  logic              prog_wr;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_data;
  logic [2:0]        ir_op;
  logic              a_eq0;
  logic              a_pos;
  logic [DATA_W-1:0] out_data;
  logic              halted;
  logic              overflow;

  modport master (
    output ir_load, pc_load, jmp_mux, mem_inst, mem_wr, a_sel, a_load, sub,
           halt, in_data, prog_wr, prog_addr, prog_data,
    input  ir_op, a_eq0, a_pos, out_data, halted, overflow
  );

  modport slave (
    input  ir_load, pc_load, jmp_mux, mem_inst, mem_wr, a_sel, a_load, sub,
           halt, in_data, prog_wr, prog_addr, prog_data,
    output ir_op, a_eq0, a_pos, out_data, halted, overflow
  );
endinterface

// File: rtl/cpu_datapath.sv
// Accumulator datapath: PC, IR, A, MDR and a unified program/data memory.
// Optional sticky signed-overflow flag is built when OVERFLOW_FLAG_EN is defined.
module cpu_datapath #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input logic           i_clk,
  input logic           i_rst,
  cpu_datapath_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [0:DEPTH-1];
  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_ir;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_mdr;
  logic              r_halted;

  logic [ADDR_W-1:0] w_addr;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [DATA_W-1:0] w_rd;
  logic [DATA_W-1:0] w_fetch;
  logic [DATA_W-1:0] w_sum;
  logic [DATA_W-1:0] w_a_src;
  logic              w_run;
  logic              w_a_eq0;

  assign w_run    = ~r_halted;
  assign w_addr   = bus.mem_inst ? r_ir[ADDR_W-1:0] : r_pc;
  assign w_pc_inc = r_pc + ADDR_W'(1);
  assign w_rd     = r_mem[w_addr];
  assign w_fetch  = r_mem[r_pc];
  assign w_sum    = bus.sub ? (r_a - r_mdr) : (r_a + r_mdr);
  assign w_a_eq0  = (r_a == {DATA_W{1'b0}});

  // Accumulator source select
  always_comb begin
    w_a_src = r_a;
    case (bus.a_sel)
      2'b00:   w_a_src = w_sum;
      2'b01:   w_a_src = bus.in_data;
      2'b10:   w_a_src = r_mdr;
      2'b11:   w_a_src = {DATA_W{1'b0}};
      default: w_a_src = r_a;
    endcase
  end

  // Memory write port: program load wins; any write seen while reset is high is dropped
  always_ff @(posedge i_clk) begin
    if (!i_rst && bus.prog_wr) begin
      r_mem[bus.prog_addr] <= bus.prog_data;
    end else if (!i_rst && bus.mem_wr && w_run) begin
      r_mem[w_addr] <= r_a;
    end
  end

  // Architectural registers, frozen while halted
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pc  <= {ADDR_W{1'b0}};
      r_ir  <= {DATA_W{1'b0}};
      r_a   <= {DATA_W{1'b0}};
      r_mdr <= {DATA_W{1'b0}};
    end else if (w_run) begin
      if (bus.ir_load) r_ir <= w_fetch;
      if (bus.pc_load) r_pc <= bus.jmp_mux ? r_ir[ADDR_W-1:0] : w_pc_inc;
      // operand capture during decode; a write cycle shares the address and must not clobber MDR
      if (bus.mem_inst && !bus.mem_wr && !bus.prog_wr) r_mdr <= w_rd;
      if (bus.a_load) r_a <= w_a_src;
    end
  end

  // Halt status register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_halted <= 1'b0;
    end else begin
      r_halted <= bus.halt;
    end
  end

`ifdef OVERFLOW_FLAG_EN
  logic r_overflow;

  function automatic logic f_signed_ovf(input logic [DATA_W-1:0] a,
                                        input logic [DATA_W-1:0] b,
                                        input logic [DATA_W-1:0] s,
                                        input logic              is_sub);
    logic b_sign;
    b_sign = is_sub ? ~b[DATA_W-1] : b[DATA_W-1];
    return (a[DATA_W-1] == b_sign) && (s[DATA_W-1] != a[DATA_W-1]);
  endfunction

  // Sticky overflow, cleared only by reset
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_overflow <= 1'b0;
    end else if (w_run && bus.a_load && (bus.a_sel == 2'b00) &&
                 f_signed_ovf(r_a, r_mdr, w_sum, bus.sub)) begin
      r_overflow <= 1'b1;
    end
  end

  assign bus.overflow = r_overflow;
`else
  assign bus.overflow = 1'b0;
`endif

  assign bus.ir_op    = r_ir[DATA_W-1:DATA_W-3];
  assign bus.a_eq0    = w_a_eq0;
  assign bus.a_pos    = ~r_a[DATA_W-1] & ~w_a_eq0;
  assign bus.out_data = r_a;
  assign bus.halted   = r_halted;
endmodule

// File: doc/cpu_datapath.md
Name: cpu_datapath

Overview:
Datapath counterpart to the processor control unit. It executes the control strobes the control unit drives: IRload, PCload, JMPmux, Meminst, MemWr, Asel, Aload, Sub and Halt. It returns the status the control unit consumes: IR opcode, Aeq0 and Apos. It holds the PC, IR, accumulator A, a memory data register (MDR) and a 32x8 unified program/data memory, plus a bench/boot program-load port.

Parameters:
DATA_W, 8, accumulator/memory word width; opcode is always the top 3 bits of IR
ADDR_W, 5, PC and address-field width; memory depth is 2**ADDR_W

Ports:
Clock  input  1  system clock, all state updates on rising edge
Reset  input  1  asynchronous, active-high reset
IRload  input  1  load IR from memory at address PC
PCload  input  1  update PC
JMPmux  input  1  PC source: 0 = PC+1, 1 = IR address field
Meminst  input  1  memory address select: 0 = PC, 1 = IR[ADDR_W-1:0]
MemWr  input  1  write A to memory at the selected address
Asel  input  2  A source: 00 = add/sub result, 01 = Input, 10 = MDR, 11 = zero
Aload  input  1  load A
Sub  input  1  adder mode: 0 = A+MDR, 1 = A-MDR
Halt  input  1  processor halted
Input  input  DATA_W  external switch value
ProgWr  input  1  program-load write strobe
ProgAddr  input  ADDR_W  program-load address
ProgData  input  DATA_W  program-load data
IR  output  3  IR[DATA_W-1:DATA_W-3], opcode to control unit
Aeq0  output  1  A == 0
Apos  output  1  A[DATA_W-1] == 0 and A != 0
Output  output  DATA_W  current A
Halted  output  1  registered copy of Halt
Overflow  output  1  sticky signed-overflow flag (see Optional Feature)

Behaviour:
- Reset (asynchronous): PC=0, IRreg=0, A=0, MDR=0, Halted=0, Overflow=0. Memory contents are not reset.
- Memory address mux: Meminst ? IRreg[ADDR_W-1:0] : PC.
- Memory read is asynchronous (combinational); memory write is synchronous.
- Write priority: ProgWr=1 writes ProgData to mem[ProgAddr] and suppresses MemWr that cycle. Otherwise MemWr=1 writes the pre-edge A to mem[addr mux].
- IR: IRload=1 loads mem[PC], using the pre-edge PC, so a fetch with IRload=1 and PCload=1 reads the old PC.
- PC: PCload=1 loads JMPmux ? IRreg[ADDR_W-1:0] : PC+1. Increment wraps 31 -> 0. Holds otherwise.
- MDR: loads mem[addr mux] on every edge where Meminst=1, MemWr=0, ProgWr=0. This captures the operand during the control unit's decode state. Load/add/sub states then use MDR regardless of Meminst.
- A: Aload=1 loads per Asel. Add/sub is DATA_W-bit two's complement, result taken mod 2**DATA_W (0x7F+0x01=0x80, 0x00-0x01=0xFF).
- Aeq0 and Apos are combinational from the registered A; valid the cycle after Aload.
- Halted follows Halt one cycle later. While Halted=1, PC, IR, A, MDR and CPU memory writes are frozen; ProgWr still works.
- Latency: strobe to register update is 1 edge. Opcode is visible on IR the cycle after the IRload edge.
- Simultaneous Aload and MemWr: memory receives the old A.
- Reset mid-instruction: all registers clear immediately; a MemWr or ProgWr in flight with Reset high is discarded.

Optional Feature:
OVERFLOW_FLAG_EN
- Defined: Overflow is set when an Aload with Asel=00 produces signed overflow. For add, operands have the same sign and the result sign differs; for sub, operands have different signs and the result sign differs from A. Overflow stays set until Reset.
- Undefined: Overflow is tied to 0 and no overflow logic is built.

Test Plan:
- Reset during activity -> PC=0, IR=000, A=0x00, Aeq0=1, Apos=0, Halted=0, next cycle.
- ProgWr mem[0]=0x05 (load 5), mem[5]=0x2A; fetch (IRload+PCload), decode (Meminst), load (Asel=10, Aload) -> IR=000, PC=1, A=0x2A, Apos=1.
- A=0x7F, MDR=0x01, Asel=00, Sub=0, Aload -> A=0x80, Apos=0, Aeq0=0; with OVERFLOW_FLAG_EN Overflow=1, without it 0.
- A=0x03, IRreg address=0x1F, Meminst=1, MemWr=1 -> mem[31]=0x03; MDR unchanged.
- A=0x00, IRreg address=0x0C, JMPmux=1, PCload=Aeq0 -> PC=0x0C. Repeat with A=0x01 -> PC unchanged.
- PC=31, IRload+PCload -> IR from mem[31], PC=0. Then Halt=1 -> Halted=1, and subsequent PCload/Aload have no effect.
